// File: rtl/sdc_traffic_gen.sv
// Host-side write/read-back traffic generator and checker
// for the SDRAM controller sdr_* request interface.
module sdc_traffic_gen #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16,
   parameter int TMO    = 1024
) (
   input  logic              mclk,
   input  logic              s_resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_adr,
   input  logic [CNT_W-1:0]  num_bursts,
   input  logic [1:0]        burst_len,
   input  logic [1:0]        pat_sel,
   input  logic [DATA_W-1:0] seed,
   input  logic              sdr_init_done,
   output logic              sdr_req,
   output logic [ADDR_W-1:0] sdr_req_adr,
   output logic [1:0]        sdr_req_len,
   output logic              sdr_req_wr_n,
   output logic [DATA_W-1:0] sdr_wr_data,
   output logic [DATA_W/8-1:0] sdr_wr_en_n,
   input  logic              sdr_req_ack,
   input  logic              sdr_wr_next,
   input  logic              sdr_rd_valid,
   input  logic [DATA_W-1:0] sdr_rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] first_err_adr
);

   localparam int WD_W = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WINIT, S_WREQ, S_WDAT,
      S_RREQ, S_RDAT, S_FIN
   } state_t;

   state_t state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  nb_q, nb_d;
   logic [1:0]        len_q, len_d;
   logic [1:0]        pat_q, pat_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [CNT_W-1:0]  b_q, b_d;
   logic [1:0]        k_q, k_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] inc_q, inc_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic pass_q, pass_d;
   logic tmo_q, tmo_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic [DATA_W-1:0] cur_data;
   logic active, is_req, is_wr;
   logic wr_cons, rd_cons, spur, mism;
   logic last_w, last_b, ev;

   // adr_q/inc_q track the current word, so address is base + w
   always_comb begin
      unique case (pat_q)
         2'd1:    cur_data = DATA_W'(adr_q);
         2'd2:    cur_data = ~inc_q;
         default: cur_data = inc_q;
      endcase
   end

   assign active = state_q inside {S_WREQ, S_WDAT, S_RREQ, S_RDAT};
   assign is_req = state_q inside {S_WREQ, S_RREQ};
   assign is_wr  = state_q inside {S_WREQ, S_WDAT};

   assign wr_cons = sdr_wr_next &&
      (state_q == S_WDAT || (state_q == S_WREQ && sdr_req_ack));
   assign rd_cons = sdr_rd_valid && state_q == S_RDAT;
   assign spur    = sdr_rd_valid && busy_q && !rd_cons;
   assign mism    = rd_cons && sdr_rd_data != cur_data;
   assign last_w  = k_q == len_q;
   assign last_b  = b_q == nb_q - CNT_W'(1);
   assign ev      = sdr_req_ack || sdr_wr_next || sdr_rd_valid;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      nb_d    = nb_q;
      len_d   = len_q;
      pat_d   = pat_q;
      seed_d  = seed_q;
      b_d     = b_q;
      k_d     = k_q;
      adr_d   = adr_q;
      inc_d   = inc_q;
      err_d   = err_q;
      first_d = first_q;
      pass_d  = pass_q;
      tmo_d   = tmo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (wr_cons || rd_cons) begin
         adr_d = adr_q + ADDR_W'(1);
         inc_d = inc_q + DATA_W'(1);
         k_d   = k_q + 2'd1;
         if (last_w) begin
            k_d = 2'd0;
            b_d = b_q + CNT_W'(1);
         end
      end
      if ((mism || spur) && err_q != '1)
         err_d = err_q + CNT_W'(1);
      if (mism && err_q == '0)
         first_d = adr_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            base_d  = base_adr;
            nb_d    = num_bursts;
            len_d   = burst_len;
            pat_d   = pat_sel;
            seed_d  = seed;
            b_d     = '0;
            k_d     = '0;
            adr_d   = base_adr;
            inc_d   = seed;
            err_d   = '0;
            first_d = '0;
            pass_d  = 1'b0;
            tmo_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = (num_bursts == '0) ? S_FIN : S_WINIT;
         end
         S_WINIT: if (sdr_init_done) state_d = S_WREQ;
         S_WREQ, S_WDAT: begin
            if (state_q == S_WREQ && sdr_req_ack)
               state_d = S_WDAT;
            if (wr_cons && last_w) begin
               state_d = S_WREQ;
               if (last_b) begin
                  state_d = S_RREQ;
                  b_d     = '0;
                  k_d     = '0;
                  adr_d   = base_q;
                  inc_d   = seed_q;
               end
            end
         end
         S_RREQ: if (sdr_req_ack) state_d = S_RDAT;
         S_RDAT: if (rd_cons && last_w)
            state_d = last_b ? S_FIN : S_RREQ;
         S_FIN: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = err_d == '0 && !tmo_q;
         end
         default: state_d = S_IDLE;
      endcase
      // watchdog fires only if no handshake arrived this cycle
      if (active && !ev && wd_q == WD_W'(TMO - 1)) begin
         state_d = S_FIN;
         tmo_d   = 1'b1;
      end
      wd_d = wd_q + WD_W'(1);
      if (!active || ev || state_d != state_q)
         wd_d = '0;
   end

   always_ff @(posedge mclk) begin
      if (!s_resetn) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         nb_q    <= '0;
         len_q   <= '0;
         pat_q   <= '0;
         seed_q  <= '0;
         b_q     <= '0;
         k_q     <= '0;
         adr_q   <= '0;
         inc_q   <= '0;
         wd_q    <= '0;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         nb_q    <= nb_d;
         len_q   <= len_d;
         pat_q   <= pat_d;
         seed_q  <= seed_d;
         b_q     <= b_d;
         k_q     <= k_d;
         adr_q   <= adr_d;
         inc_q   <= inc_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         first_q <= first_d;
         pass_q  <= pass_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sdr_req       = is_req;
   assign sdr_req_adr   = is_req ? adr_q : '0;
   assign sdr_req_len   = is_req ? len_q : 2'd0;
   assign sdr_req_wr_n  = !is_wr;
   assign sdr_wr_data   = is_wr ? cur_data : '0;
   assign sdr_wr_en_n   = is_wr ? '0 : '1;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign timeout       = tmo_q;
   assign err_cnt       = err_q;
   assign first_err_adr = first_q;

endmodule

// File: tb/tb_sdc_traffic_gen.sv
// Directed bench for sdc_traffic_gen with a controller model
// and a write-word scoreboard.
module tb_sdc_traffic_gen;

   localparam int AW  = 22;
   localparam int DW  = 32;
   localparam int CW  = 16;
   localparam int TMO = 1024;

   logic mclk = 1'b0;
   always #5 mclk = ~mclk;

   logic          s_resetn;
   logic          start;
   logic [AW-1:0] base_adr;
   logic [CW-1:0] num_bursts;
   logic [1:0]    burst_len;
   logic [1:0]    pat_sel;
   logic [DW-1:0] seed;
   logic          sdr_init_done;
   logic          sdr_req;
   logic [AW-1:0] sdr_req_adr;
   logic [1:0]    sdr_req_len;
   logic          sdr_req_wr_n;
   logic [DW-1:0] sdr_wr_data;
   logic [DW/8-1:0] sdr_wr_en_n;
   logic          sdr_req_ack;
   logic          sdr_wr_next;
   logic          sdr_rd_valid;
   logic [DW-1:0] sdr_rd_data;
   logic          busy, done, pass, timeout;
   logic [CW-1:0] err_cnt;
   logic [AW-1:0] first_err_adr;

   sdc_traffic_gen #(
      .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TMO(TMO)
   ) dut (
      .mclk(mclk), .s_resetn(s_resetn), .start(start),
      .base_adr(base_adr), .num_bursts(num_bursts),
      .burst_len(burst_len), .pat_sel(pat_sel), .seed(seed),
      .sdr_init_done(sdr_init_done), .sdr_req(sdr_req),
      .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
      .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data),
      .sdr_wr_en_n(sdr_wr_en_n), .sdr_req_ack(sdr_req_ack),
      .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
      .sdr_rd_data(sdr_rd_data), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
      .first_err_adr(first_err_adr)
   );

   typedef struct packed {
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } wexp_t;

   wexp_t         exp_q[$];
   logic [DW-1:0] mem [logic [AW-1:0]];
   int            checks = 0;
   int            failures = 0;
   bit            ack_en = 1'b1;
   bit            corrupt = 1'b0;
   logic [AW-1:0] bad_adr = '0;
   logic [1:0]    cur_len = '0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // controller model: ack, then one word per cycle
   initial begin
      int            n;
      logic [AW-1:0] a;
      bit            wr;
      bit            xfer;
      wexp_t         e;
      xfer = 1'b0;
      n = 0;
      a = '0;
      wr = 1'b0;
      sdr_req_ack = 1'b0;
      sdr_wr_next = 1'b0;
      sdr_rd_valid = 1'b0;
      sdr_rd_data = '0;
      forever begin
         @(negedge mclk);
         sdr_req_ack = 1'b0;
         sdr_wr_next = 1'b0;
         sdr_rd_valid = 1'b0;
         sdr_rd_data = '0;
         if (!s_resetn) begin
            xfer = 1'b0;
         end else if (xfer) begin
            if (wr) begin
               sdr_wr_next = 1'b1;
               chk("wr_en_n", 64'(sdr_wr_en_n), 64'd0);
               chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("wr_adr", 64'(a), 64'(e.adr));
                  chk("wr_dat", 64'(sdr_wr_data), 64'(e.dat));
               end
               mem[a] = sdr_wr_data;
            end else begin
               sdr_rd_valid = 1'b1;
               sdr_rd_data = mem.exists(a) ? mem[a] : '0;
               if (corrupt && a == bad_adr) sdr_rd_data = '0;
            end
            a = a + AW'(1);
            n--;
            if (n == 0) xfer = 1'b0;
         end else if (sdr_req && ack_en) begin
            sdr_req_ack = 1'b1;
            a = sdr_req_adr;
            wr = !sdr_req_wr_n;
            n = int'(sdr_req_len) + 1;
            xfer = 1'b1;
            chk("req_len", 64'(sdr_req_len), 64'(cur_len));
         end
      end
   end

   task automatic setup(input logic [AW-1:0] b, input int nb,
                        input logic [1:0] len, input logic [1:0] p,
                        input logic [DW-1:0] s);
      wexp_t e;
      logic [DW-1:0] inc;
      base_adr = b;
      num_bursts = CW'(nb);
      burst_len = len;
      pat_sel = p;
      seed = s;
      cur_len = len;
      exp_q.delete();
      mem.delete();
      for (int w = 0; w < nb * (int'(len) + 1); w++) begin
         e.adr = b + AW'(w);
         inc = s + DW'(w);
         if (p == 2'd1) e.dat = DW'(e.adr);
         else if (p == 2'd2) e.dat = ~inc;
         else e.dat = inc;
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start();
      @(negedge mclk);
      start = 1'b1;
      @(negedge mclk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int reqc);
      int cyc;
      cyc = 0;
      reqc = 0;
      while (!done && cyc < max) begin
         @(negedge mclk);
         if (sdr_req) reqc++;
         cyc++;
      end
      chk("done_seen", 64'(done), 64'd1);
   endtask

   task automatic end_checks(input string tag, input logic p,
                             input logic t, input int e);
      chk({tag, "_pass"}, 64'(pass), 64'(p));
      chk({tag, "_timeout"}, 64'(timeout), 64'(t));
      chk({tag, "_err"}, 64'(err_cnt), 64'(e));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      @(negedge mclk);
      chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
   endtask

   initial begin
      int rc;
      s_resetn = 1'b0;
      start = 1'b0;
      sdr_init_done = 1'b0;
      base_adr = '0;
      num_bursts = '0;
      burst_len = '0;
      pat_sel = '0;
      seed = '0;
      repeat (3) @(negedge mclk);
      chk("rst_req", 64'(sdr_req), 64'd0);
      chk("rst_wr_n", 64'(sdr_req_wr_n), 64'd1);
      chk("rst_en_n", 64'(sdr_wr_en_n), 64'hF);
      chk("rst_busy", 64'(busy), 64'd0);
      s_resetn = 1'b1;

      // ideal run, init_done late
      setup(22'h100, 2, 2'd3, 2'd0, 32'hA0);
      pulse_start();
      repeat (5) @(negedge mclk);
      chk("winit_noreq", 64'(sdr_req), 64'd0);
      chk("winit_busy", 64'(busy), 64'd1);
      sdr_init_done = 1'b1;
      wait_done(500, rc);
      chk("t1_first", 64'(first_err_adr), 64'd0);
      chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
      end_checks("t1", 1'b1, 1'b0, 0);

      // corrupted read of 0x105
      setup(22'h100, 2, 2'd3, 2'd0, 32'hA0);
      corrupt = 1'b1;
      bad_adr = 22'h105;
      pulse_start();
      wait_done(500, rc);
      chk("t2_first", 64'(first_err_adr), 64'h105);
      end_checks("t2", 1'b0, 1'b0, 1);
      corrupt = 1'b0;

      // never acked: watchdog
      setup(22'h200, 1, 2'd1, 2'd0, 32'h0);
      ack_en = 1'b0;
      pulse_start();
      wait_done(3000, rc);
      chk("t3_req_cycles", 64'(rc), 64'(TMO));
      end_checks("t3", 1'b0, 1'b1, 0);
      ack_en = 1'b1;

      // address wrap, address-as-data
      setup(22'h3FFFFE, 1, 2'd3, 2'd1, 32'h1234);
      pulse_start();
      wait_done(500, rc);
      chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
      end_checks("t4", 1'b1, 1'b0, 0);

      // reset during write data
      setup(22'h40, 2, 2'd3, 2'd2, 32'h7);
      pulse_start();
      rc = 0;
      while (!(busy && !sdr_req && !sdr_req_wr_n) && rc < 50) begin
         @(posedge mclk);
         #1;
         rc++;
      end
      chk("t5_in_wdata", 64'(rc < 50), 64'd1);
      s_resetn = 1'b0;
      @(posedge mclk);
      #1;
      chk("t5_req", 64'(sdr_req), 64'd0);
      chk("t5_wr_n", 64'(sdr_req_wr_n), 64'd1);
      chk("t5_en_n", 64'(sdr_wr_en_n), 64'hF);
      chk("t5_wdata", 64'(sdr_wr_data), 64'd0);
      chk("t5_radr", 64'(sdr_req_adr), 64'd0);
      chk("t5_stat", 64'({busy, done, pass, timeout}), 64'd0);
      s_resetn = 1'b1;
      setup(22'h40, 2, 2'd3, 2'd2, 32'h7);
      pulse_start();
      wait_done(500, rc);
      chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
      end_checks("t5", 1'b1, 1'b0, 0);

      // zero bursts
      setup(22'h10, 0, 2'd0, 2'd0, 32'h0);
      pulse_start();
      chk("t6_done_c1", 64'(done), 64'd0);
      chk("t6_busy_c1", 64'(busy), 64'd1);
      @(negedge mclk);
      chk("t6_done_c2", 64'(done), 64'd1);
      chk("t6_noreq", 64'(sdr_req), 64'd0);
      end_checks("t6", 1'b1, 1'b0, 0);

      // start while busy is ignored
      setup(22'h20, 2, 2'd1, 2'd2, 32'h55);
      pulse_start();
      repeat (3) @(negedge mclk);
      num_bursts = '0;
      pulse_start();
      chk("t7_still_busy", 64'(busy), 64'd1);
      chk("t7_no_done", 64'(done), 64'd0);
      wait_done(500, rc);
      chk("t7_sb_empty", 64'(exp_q.size()), 64'd0);
      end_checks("t7", 1'b1, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
